// File: rtl/zube_fifo_if.sv
// zube_fifo_if: Z80 strobe bus and SoC valid/ready streams for the zube_fifo mailbox.
//   slave  : the mailbox block (samples Z80 strobes, drives read data, TX stream, RX ready)
//   master : the surrounding system (Z80 bus model and SoC endpoints)
interface zube_fifo_if;
    logic       z80_write_strobe_b;
    logic       z80_read_strobe_b;
    logic [7:0] z80_address_bus;
    logic [7:0] z80_data_bus_in;
    logic [7:0] z80_data_bus_out;
    logic       z80_bus_dir;
    logic       z80_int_b;
    logic [7:0] soc_tx_data;
    logic       soc_tx_valid;
    logic       soc_tx_ready;
    logic [7:0] soc_rx_data;
    logic       soc_rx_valid;
    logic       soc_rx_ready;

    modport slave (
        input  z80_write_strobe_b, z80_read_strobe_b, z80_address_bus, z80_data_bus_in,
        input  soc_tx_ready, soc_rx_data, soc_rx_valid,
        output z80_data_bus_out, z80_bus_dir, z80_int_b,
        output soc_tx_data, soc_tx_valid, soc_rx_ready
    );

    modport master (
        output z80_write_strobe_b, z80_read_strobe_b, z80_address_bus, z80_data_bus_in,
        output soc_tx_ready, soc_rx_data, soc_rx_valid,
        input  z80_data_bus_out, z80_bus_dir, z80_int_b,
        input  soc_tx_data, soc_tx_valid, soc_rx_ready
    );
endinterface

// File: rtl/zube_fifo.sv
// zube_fifo: Z80 I/O-port mailbox with a TX FIFO (Z80 writes -> SoC) and an RX FIFO
// (SoC -> Z80 reads).
//   clk, reset_b : system clock, asynchronous active-low reset
//   bus (slave)  : Z80 strobes/address/data, bus direction, interrupt, SoC TX/RX streams
// Register map: BASE_ADDR = DATA, BASE_ADDR+1 = STATUS (read) / CONTROL (write).
// Optional interrupt: define ZUBE_FIFO_IRQ_EN; without it z80_int_b is tied high.
module zube_fifo #(
    parameter logic [7:0]  BASE_ADDR   = 8'h80,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        reset_b,
    zube_fifo_if.slave bus
);
    localparam int unsigned PW        = $clog2(DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam logic [7:0]  CTRL_ADDR = BASE_ADDR + 8'd1;

    // Strobe synchronisers, edge detect and arming
    logic [SYNC_STAGES-1:0] wr_sync, rd_sync, settle;
    logic wr_prev, rd_prev, wr_armed, rd_armed;
    logic wr_fall, rd_fall, rd_rise;

    // A strobe only arms once the chain has flushed its reset value and shown a real
    // high level, so a strobe already low at reset release never fires.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_sync  <= '1;
            rd_sync  <= '1;
            settle   <= '0;
            wr_prev  <= 1'b1;
            rd_prev  <= 1'b1;
            wr_armed <= 1'b0;
            rd_armed <= 1'b0;
        end else begin
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], bus.z80_write_strobe_b};
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0], bus.z80_read_strobe_b};
            settle   <= {settle[SYNC_STAGES-2:0], 1'b1};
            wr_prev  <= wr_sync[SYNC_STAGES-1];
            rd_prev  <= rd_sync[SYNC_STAGES-1];
            wr_armed <= wr_armed | (settle[SYNC_STAGES-1] & wr_sync[SYNC_STAGES-1]);
            rd_armed <= rd_armed | (settle[SYNC_STAGES-1] & rd_sync[SYNC_STAGES-1]);
        end
    end

    assign wr_fall = wr_armed & wr_prev & ~wr_sync[SYNC_STAGES-1];
    assign rd_fall = rd_armed & rd_prev & ~rd_sync[SYNC_STAGES-1];
    assign rd_rise = ~rd_prev & rd_sync[SYNC_STAGES-1];

    // Address decode in the edge cycle
    logic wr_data_hit, wr_ctrl_hit, rd_data_hit, rd_stat_hit, flush;
    assign wr_data_hit = wr_fall && (bus.z80_address_bus == BASE_ADDR);
    assign wr_ctrl_hit = wr_fall && (bus.z80_address_bus == CTRL_ADDR);
    assign rd_data_hit = rd_fall && (bus.z80_address_bus == BASE_ADDR);
    assign rd_stat_hit = rd_fall && (bus.z80_address_bus == CTRL_ADDR);
    assign flush       = wr_ctrl_hit && bus.z80_data_bus_in[7];

    // FIFO storage and state
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_ovf, rx_udf, tx_ovf_set, rx_udf_set;
    logic          pop_pending, irq_en_bit;
    logic [7:0]    status, data_out_q;
    logic          bus_dir_q;

    assign tx_full  = (tx_cnt == CW'(DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(DEPTH));
    assign rx_empty = (rx_cnt == '0);

    // Flush wins over any same-cycle SoC transfer; a full TX still accepts alongside a pop.
    assign tx_pop     = !tx_empty && bus.soc_tx_ready && !flush;
    assign tx_push    = wr_data_hit && (!tx_full || tx_pop);
    assign tx_ovf_set = wr_data_hit && tx_full && !tx_pop;
    assign rx_push    = bus.soc_rx_valid && !rx_full && !flush;
    assign rx_pop     = rd_rise && pop_pending && !rx_empty && !flush;
    assign rx_udf_set = rd_data_hit && rx_empty;

    assign status = {1'b0, irq_en_bit, rx_full, tx_empty, tx_ovf, rx_udf, !tx_full, !rx_empty};

    // Payload storage, no reset needed
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= bus.z80_data_bus_in;
        if (rx_push) rx_mem[rx_wr] <= bus.soc_rx_data;
    end

    // Pointers, counts, sticky flags and Z80 read path
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_cnt      <= '0;
            rx_wr       <= '0;
            rx_rd       <= '0;
            rx_cnt      <= '0;
            tx_ovf      <= 1'b0;
            rx_udf      <= 1'b0;
            pop_pending <= 1'b0;
            data_out_q  <= 8'h00;
            bus_dir_q   <= 1'b0;
        end else begin
            if (flush) begin
                tx_wr  <= '0;
                tx_rd  <= '0;
                tx_cnt <= '0;
                rx_wr  <= '0;
                rx_rd  <= '0;
                rx_cnt <= '0;
            end else begin
                if (tx_push) tx_wr <= tx_wr + PW'(1);
                if (tx_pop)  tx_rd <= tx_rd + PW'(1);
                if (rx_push) rx_wr <= rx_wr + PW'(1);
                if (rx_pop)  rx_rd <= rx_rd + PW'(1);
                tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
                rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            end

            // Set wins over a same-cycle write-1-to-clear
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr_ctrl_hit & bus.z80_data_bus_in[3]));
            rx_udf <= rx_udf_set | (rx_udf & ~(wr_ctrl_hit & bus.z80_data_bus_in[2]));

            if (rd_data_hit) begin
                bus_dir_q   <= 1'b1;
                data_out_q  <= rx_empty ? 8'h00 : rx_mem[rx_rd];
                pop_pending <= !rx_empty;
            end else if (rd_stat_hit) begin
                bus_dir_q  <= 1'b1;
                data_out_q <= status;
            end else if (rd_rise) begin
                bus_dir_q   <= 1'b0;
                pop_pending <= 1'b0;
            end else if (flush) begin
                pop_pending <= 1'b0;
            end
        end
    end

    assign bus.z80_data_bus_out = data_out_q;
    assign bus.z80_bus_dir      = bus_dir_q;
    assign bus.soc_tx_data      = tx_mem[tx_rd];
    assign bus.soc_tx_valid     = !tx_empty;
    assign bus.soc_rx_ready     = !rx_full;

`ifdef ZUBE_FIFO_IRQ_EN
    // Interrupt enable and registered active-low request
    logic irq_en, int_b_q;
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            irq_en  <= 1'b0;
            int_b_q <= 1'b1;
        end else begin
            if (wr_ctrl_hit) irq_en <= bus.z80_data_bus_in[6];
            int_b_q <= ~(irq_en & (!rx_empty | rx_udf | tx_ovf));
        end
    end
    assign irq_en_bit    = irq_en;
    assign bus.z80_int_b = int_b_q;
`else
    assign irq_en_bit    = 1'b0;
    assign bus.z80_int_b = 1'b1;
`endif
endmodule
